// File: rtl/junction_light_ctrl.sv
// junction_light_ctrl
// Self-timed highway / country-road junction controller. A six-phase FSM
// with its own tick-driven phase counter walks HG -> HY -> AR1 -> CG -> CY
// -> AR2. The country road gets green only while a car is sensed, capped at
// T_CR_MAX ticks. Lamp outputs are one-hot {G,Y,R} and are registered from
// the next state, so they change on the same edge as the phase.
// Optional feature macro: PED_REQ_EN (pedestrian request latch + walk lamp).
module junction_light_ctrl #(
    parameter int CNT_W     = 8,
    parameter int T_HWY_MIN = 10,
    parameter int T_YEL     = 3,
    parameter int T_ALLRED  = 1,
    parameter int T_CR_MAX  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       sensor,
    output logic [2:0] highway_led,
    output logic [2:0] country_led,
    output logic [2:0] phase
`ifdef PED_REQ_EN
    ,
    input  logic       ped_req,
    output logic       ped_walk
`endif
);

    typedef enum logic [2:0] {
        S_HG  = 3'd0,
        S_HY  = 3'd1,
        S_AR1 = 3'd2,
        S_CG  = 3'd3,
        S_CY  = 3'd4,
        S_AR2 = 3'd5
    } state_t;

    // Last counter value of each timed phase ("done" fires on a tick here).
    localparam logic [CNT_W-1:0] HWY_LAST = CNT_W'(T_HWY_MIN - 1);
    localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(T_YEL - 1);
    localparam logic [CNT_W-1:0] AR_LAST  = CNT_W'(T_ALLRED - 1);
    localparam logic [CNT_W-1:0] CR_LAST  = CNT_W'(T_CR_MAX - 1);

    localparam logic [2:0] LED_G = 3'b100;
    localparam logic [2:0] LED_Y = 3'b010;
    localparam logic [2:0] LED_R = 3'b001;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       highway_led_reg, highway_led_next;
    logic [2:0]       country_led_reg, country_led_next;
    logic             req;

`ifdef PED_REQ_EN
    logic ped_latch_reg, ped_latch_next;

    assign req      = sensor | ped_latch_reg;
    assign ped_walk = (state_reg == S_CG) && ped_latch_reg;

    // Pedestrian latch: sticky until CY is entered; a same-cycle request survives the clear.
    always_comb begin
        ped_latch_next = ped_latch_reg | ped_req;
        if (state_next == S_CY && state_reg != S_CY) begin
            ped_latch_next = ped_req;
        end
    end

    // Pedestrian latch register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ped_latch_reg <= 1'b0;
        end else begin
            ped_latch_reg <= ped_latch_next;
        end
    end
`else
    assign req = sensor;
`endif

    // Next-state and phase-counter logic; nothing moves without a tick.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            S_HG: begin
                if (tick) begin
                    // Counter saturates at the minimum-green point and waits for a request.
                    if (cnt_reg >= HWY_LAST) begin
                        if (req) state_next = S_HY;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            S_HY: begin
                if (tick) begin
                    if (cnt_reg == YEL_LAST) state_next = S_AR1;
                    else                     cnt_next   = cnt_reg + 1'b1;
                end
            end
            S_AR1: begin
                if (tick) begin
                    if (cnt_reg == AR_LAST) state_next = S_CG;
                    else                    cnt_next   = cnt_reg + 1'b1;
                end
            end
            S_CG: begin
                // Country green ends at max-green or as soon as the road is empty on a tick.
                if (tick) begin
                    if (cnt_reg == CR_LAST || !sensor) state_next = S_CY;
                    else                               cnt_next   = cnt_reg + 1'b1;
                end
            end
            S_CY: begin
                if (tick) begin
                    if (cnt_reg == YEL_LAST) state_next = S_AR2;
                    else                     cnt_next   = cnt_reg + 1'b1;
                end
            end
            S_AR2: begin
                if (tick) begin
                    if (cnt_reg == AR_LAST) state_next = S_HG;
                    else                    cnt_next   = cnt_reg + 1'b1;
                end
            end
            default: begin
                // Illegal codes fall back to highway green.
                state_next = S_HG;
            end
        endcase
        if (state_next != state_reg) begin
            cnt_next = '0;
        end
    end

    // Lamp decode from the next state so the registered lamps track the phase edge.
    always_comb begin
        highway_led_next = LED_R;
        country_led_next = LED_R;
        case (state_next)
            S_HG:    highway_led_next = LED_G;
            S_HY:    highway_led_next = LED_Y;
            S_CG:    country_led_next = LED_G;
            S_CY:    country_led_next = LED_Y;
            default: begin
                highway_led_next = LED_R;
                country_led_next = LED_R;
            end
        endcase
    end

    // State, counter and lamp registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= S_HG;
            cnt_reg         <= '0;
            highway_led_reg <= LED_G;
            country_led_reg <= LED_R;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            highway_led_reg <= highway_led_next;
            country_led_reg <= country_led_next;
        end
    end

    assign highway_led = highway_led_reg;
    assign country_led = country_led_reg;
    assign phase       = state_reg;

endmodule

// File: tb/tb_junction_light_ctrl.sv
// tb_junction_light_ctrl
// Every cycle the DUT is compared with a phase/elapsed-tick model of the
// junction; directed scenarios pin the model with literal expectations and a
// random phase exercises tick, sensor, reset (and pedestrian requests when
// PED_REQ_EN is defined).
module tb_junction_light_ctrl;

    localparam int CNT_W     = 8;
    localparam int T_HWY_MIN = 10;
    localparam int T_YEL     = 3;
    localparam int T_ALLRED  = 1;
    localparam int T_CR_MAX  = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       sensor = 1'b0;
    logic [2:0] highway_led, country_led, phase;
`ifdef PED_REQ_EN
    logic       ped_req = 1'b0;
    logic       ped_walk;
`endif

    int tests = 0;
    int fails = 0;

    // Model: current phase index and number of ticks spent in it.
    int m_ph    = 0;
    int m_el    = 0;
    bit m_latch = 1'b0;

    junction_light_ctrl #(
        .CNT_W(CNT_W), .T_HWY_MIN(T_HWY_MIN), .T_YEL(T_YEL),
        .T_ALLRED(T_ALLRED), .T_CR_MAX(T_CR_MAX)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .sensor(sensor),
        .highway_led(highway_led), .country_led(country_led), .phase(phase)
`ifdef PED_REQ_EN
        , .ped_req(ped_req), .ped_walk(ped_walk)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dur_of(input int p);
        case (p)
            0: return T_HWY_MIN;
            1: return T_YEL;
            2: return T_ALLRED;
            3: return T_CR_MAX;
            4: return T_YEL;
            default: return T_ALLRED;
        endcase
    endfunction

    function automatic logic [2:0] hwy_of(input int p);
        if (p == 0) return 3'b100;
        if (p == 1) return 3'b010;
        return 3'b001;
    endfunction

    function automatic logic [2:0] cr_of(input int p);
        if (p == 3) return 3'b100;
        if (p == 4) return 3'b010;
        return 3'b001;
    endfunction

    function automatic bit onehot3(input logic [2:0] v);
        return (v == 3'b100) || (v == 3'b010) || (v == 3'b001);
    endfunction

    // Model update on each edge, then a compare of all outputs 1 time unit later.
    always @(posedge clk) begin
        int  nph, nel;
        bit  nlatch, req, leave, pr;
        nph = m_ph;
        nel = m_el;
        nlatch = m_latch;
`ifdef PED_REQ_EN
        pr = ped_req;
`else
        pr = 1'b0;
`endif
        if (rst) begin
            nph = 0; nel = 0; nlatch = 1'b0;
        end else begin
            req = sensor || m_latch;
            leave = 1'b0;
            if (tick) begin
                if (m_ph == 0)      leave = (m_el + 1 >= T_HWY_MIN) && req;
                else if (m_ph == 3) leave = (m_el + 1 == T_CR_MAX) || !sensor;
                else                leave = (m_el + 1 == dur_of(m_ph));
                if (leave) begin
                    nph = (m_ph + 1) % 6;
                    nel = 0;
                end else begin
                    nel = m_el + 1;
                end
            end
            if (nph == 4 && m_ph != 4) nlatch = pr;
            else                       nlatch = m_latch | pr;
        end
        m_ph = nph; m_el = nel; m_latch = nlatch;
        #1;
        check("phase", phase, m_ph);
        check("highway_led", highway_led, hwy_of(m_ph));
        check("country_led", country_led, cr_of(m_ph));
        check("safety", onehot3(highway_led) && onehot3(country_led) &&
                        (highway_led == 3'b001 || country_led == 3'b001), 1);
`ifdef PED_REQ_EN
        check("ped_walk", ped_walk, (m_ph == 3) && m_latch);
`endif
    end

    task automatic wait_phase(input logic [2:0] p, input int budget, input string nm);
        int n = 0;
        while (phase !== p && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(nm, phase, p);
    endtask

    initial begin
        int exp_seq[$];
        int lens[6];
        int n, hold_err, run;
        bit run_done, prev_tick;
        logic [2:0] prev_ph;

        // Reset state
        rst = 1'b1; tick = 1'b0; sensor = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_phase", phase, 0);
        check("reset_hwy", highway_led, 3'b100);
        check("reset_cr", country_led, 3'b001);
        rst = 1'b0;
        $display("[TB] reset checked");

        // Full cycle, sensor held high, tick every cycle
        lens[0] = 9; lens[1] = 3; lens[2] = 1; lens[3] = 8; lens[4] = 3; lens[5] = 1;
        for (int p = 0; p < 6; p++)
            for (int k = 0; k < lens[p]; k++) exp_seq.push_back(p);
        repeat (4) exp_seq.push_back(0);
        sensor = 1'b1; tick = 1'b1;
        foreach (exp_seq[i]) begin
            @(negedge clk);
            check("cycle_seq", phase, exp_seq[i]);
        end
        $display("[TB] full cycle with sensor high checked");

        // No demand: HG holds, then leaves on the first tick with demand
        sensor = 1'b0;
        hold_err = 0;
        repeat (50) begin
            @(negedge clk);
            if (phase !== 3'd0) hold_err++;
        end
        check("hg_hold", hold_err, 0);
        sensor = 1'b1;
        @(negedge clk);
        check("hg_exit_first_tick", phase, 1);
        $display("[TB] highway hold and release checked");

        // Country green cut short after 3 ticks
        wait_phase(3'd3, 20, "reach_cg");
        @(negedge clk); check("cg_tick1", phase, 3);
        @(negedge clk); check("cg_tick2", phase, 3);
        sensor = 1'b0;
        @(negedge clk); check("cg_cut", phase, 4);
        $display("[TB] early country-green end checked");

        // Tick every 4th cycle
        sensor = 1'b1;
        hold_err = 0; run = 0; run_done = 1'b0;
        for (int k = 0; k < 200; k++) begin
            tick = (k % 4 == 0);
            prev_ph = phase;
            prev_tick = tick;
            @(negedge clk);
            if (!prev_tick && phase !== prev_ph) hold_err++;
            if (phase === 3'd1) begin
                if (!run_done) run++;
            end else if (run > 0) begin
                run_done = 1'b1;
            end
        end
        check("notick_hold", hold_err, 0);
        check("hy_len_x4", run, 12);
        $display("[TB] slow tick scaling checked");

        // Reset in the middle of CY
        tick = 1'b1; sensor = 1'b1;
        wait_phase(3'd4, 60, "reach_cy");
        @(negedge clk); check("cy_cnt1", phase, 4);
        rst = 1'b1;
        @(negedge clk);
        check("midcy_rst_phase", phase, 0);
        check("midcy_rst_hwy", highway_led, 3'b100);
        check("midcy_rst_cr", country_led, 3'b001);
        rst = 1'b0;
        n = 0;
        while (phase === 3'd0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("hg_len_after_rst", n, 10);
        $display("[TB] mid-CY reset checked");

`ifdef PED_REQ_EN
        // Pedestrian request with no car waiting
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        sensor = 1'b0; tick = 1'b1;
        repeat (12) @(negedge clk);
        tick = 1'b0; ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
        check("ped_no_tick_hold", phase, 0);
        tick = 1'b1;
        @(negedge clk);
        check("ped_hy", phase, 1);
        wait_phase(3'd3, 10, "ped_reach_cg");
        check("ped_walk_cg", ped_walk, 1);
        @(negedge clk);
        check("ped_cg_cut", phase, 4);
        check("ped_walk_cy", ped_walk, 0);
        $display("[TB] pedestrian request checked");
`endif

        // Random stimulus against the model
        for (int k = 0; k < 3000; k++) begin
            rst  = ($urandom_range(0, 299) == 0);
            tick = $urandom_range(0, 1);
            if ($urandom_range(0, 7) == 0) sensor = ~sensor;
`ifdef PED_REQ_EN
            ped_req = ($urandom_range(0, 19) == 0);
`endif
            @(negedge clk);
        end
        rst = 1'b0;
        $display("[TB] random run complete");

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
